// File: rtl/gpio_serial_loader.sv
// Snapshots the parallel GPIO default straps, shifts them MSB-first into the GPIO
// configuration chain, then pulses serial_load so the pads adopt the new settings.
module gpio_serial_loader #(
   parameter int NUM_IO   = 19,
   parameter int CFG_BITS = 13,
   parameter int CLK_DIV  = 4
) (
   input  logic                         wb_clk_i,
   input  logic                         wb_rst_i,
   input  logic                         start,
   input  logic [NUM_IO*CFG_BITS-1:0]   defaults,
   output logic                         serial_clock,
   output logic                         serial_data,
   output logic                         serial_load,
   output logic                         busy,
   output logic                         done
);

   localparam int NBITS = NUM_IO * CFG_BITS;
   localparam int BW    = $clog2(NBITS + 1);
   localparam int PW    = $clog2(CLK_DIV + 1);

   localparam logic [BW-1:0] LAST_BIT   = BW'(NBITS - 1);
   localparam logic [PW-1:0] LAST_PHASE = PW'(CLK_DIV - 1);

   localparam logic [2:0] IDLE     = 3'd0;
   localparam logic [2:0] SHIFT_LO = 3'd1;
   localparam logic [2:0] SHIFT_HI = 3'd2;
   localparam logic [2:0] LOAD     = 3'd3;
   localparam logic [2:0] FIN      = 3'd4;

   logic [2:0]       state;
   logic [PW-1:0]    phase;
   logic [BW-1:0]    bit_cnt;
   logic [NBITS-1:0] shreg;
   logic [NBITS-1:0] shreg_next;
   logic             phase_end;

   // The top bit of the shift register is always the bit currently on the chain.
   assign shreg_next = shreg << 1;
   assign phase_end  = (phase == LAST_PHASE);

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state        <= IDLE;
         phase        <= '0;
         bit_cnt      <= '0;
         shreg        <= '0;
         serial_clock <= 1'b0;
         serial_data  <= 1'b0;
         serial_load  <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  shreg        <= defaults;
                  serial_data  <= defaults[NBITS-1];
                  serial_clock <= 1'b0;
                  busy         <= 1'b1;
                  phase        <= '0;
                  bit_cnt      <= '0;
                  state        <= SHIFT_LO;
               end
            end

            SHIFT_LO: begin
               if (phase_end) begin
                  phase        <= '0;
                  serial_clock <= 1'b1;
                  state        <= SHIFT_HI;
               end else begin
                  phase <= phase + 1'b1;
               end
            end

            // Data only moves on the falling side so the chain always sees a stable bit.
            SHIFT_HI: begin
               if (phase_end) begin
                  phase        <= '0;
                  serial_clock <= 1'b0;
                  if (bit_cnt == LAST_BIT) begin
                     bit_cnt     <= bit_cnt + 1'b1;
                     serial_data <= 1'b0;
                     serial_load <= 1'b1;
                     state       <= LOAD;
                  end else begin
                     bit_cnt     <= bit_cnt + 1'b1;
                     shreg       <= shreg_next;
                     serial_data <= shreg_next[NBITS-1];
                     state       <= SHIFT_LO;
                  end
               end else begin
                  phase <= phase + 1'b1;
               end
            end

            LOAD: begin
               if (phase_end) begin
                  phase       <= '0;
                  serial_load <= 1'b0;
                  busy        <= 1'b0;
                  done        <= 1'b1;
                  state       <= FIN;
               end else begin
                  phase <= phase + 1'b1;
               end
            end

            FIN: begin
               done  <= 1'b0;
               state <= IDLE;
            end

            default: begin
               state        <= IDLE;
               phase        <= '0;
               serial_clock <= 1'b0;
               serial_load  <= 1'b0;
               busy         <= 1'b0;
               done         <= 1'b0;
            end
         endcase
      end
   end

endmodule
